// File: rtl/blackjack_round_ctrl.sv
// -----------------------------------------------------------------------------
// blackjack_round_ctrl
// Sequences one blackjack round around a free-running 1..10 card counter:
// deals P,D,P,D from card_in_i, serves player hits/stands from the raw KEY
// buttons, plays the dealer automatically and posts win/lose/push.
//
// Ports
//   clock            system clock
//   reset_n          asynchronous, active-low reset
//   hit_n_i          raw active-low button: start round / hit / acknowledge
//   stand_n_i        raw active-low button: stand / acknowledge
//   card_in_i[3:0]   current counter value (0 and 11..15 read as 10)
//   card_take_o      1-clock strobe, card_in_i sampled this cycle
//   player_total_o   best player total (soft ace applied)
//   dealer_total_o   best dealer total (soft ace applied)
//   state_o[2:0]     FSM state code
//   busy_o           1 in every state except IDLE and RESULT
//   win_o/lose_o/push_o  result flags, only set in RESULT
// -----------------------------------------------------------------------------
module blackjack_round_ctrl #(
    parameter int DEALER_STAND = 17,
    parameter int DRAW_GAP     = 7
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       hit_n_i,
    input  logic       stand_n_i,
    input  logic [3:0] card_in_i,
    output logic       card_take_o,
    output logic [4:0] player_total_o,
    output logic [4:0] dealer_total_o,
    output logic [2:0] state_o,
    output logic       busy_o,
    output logic       win_o,
    output logic       lose_o,
    output logic       push_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DEAL_P1 = 3'd1,
        ST_DEAL_D1 = 3'd2,
        ST_DEAL_P2 = 3'd3,
        ST_DEAL_D2 = 3'd4,
        ST_PLAYER  = 3'd5,
        ST_DEALER  = 3'd6,
        ST_RESULT  = 3'd7
    } state_t;

    localparam int               GAP_W       = (DRAW_GAP > 2) ? $clog2(DRAW_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD    = GAP_W'(DRAW_GAP - 1);
    localparam logic [4:0]       STAND_TOTAL = 5'(DEALER_STAND);

    // ---------------- button synchronizers and falling-edge detect -----------
    // Bit 0 = hit, bit 1 = stand. Released level is 1, so a press is 1->0.
    logic [1:0] btn_n;
    logic [1:0] btn_ev;
    logic       hit_ev;
    logic       stand_ev;

    assign btn_n = {stand_n_i, hit_n_i};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic sync1_q;
            logic sync2_q;
            logic prev_q;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    sync1_q <= 1'b1;
                    sync2_q <= 1'b1;
                    prev_q  <= 1'b1;
                end else begin
                    sync1_q <= btn_n[gi];
                    sync2_q <= sync1_q;
                    prev_q  <= sync2_q;
                end
            end

            // One pulse per falling edge of the synchronized level; holding
            // the button keeps both flops at 0 and yields no further events.
            assign btn_ev[gi] = prev_q & ~sync2_q;
        end
    endgenerate

    assign hit_ev   = btn_ev[0];
    assign stand_ev = btn_ev[1];

    // ---------------- card value and hand arithmetic -------------------------
    logic [4:0] card_val;
    logic       card_is_ace;

    always_comb begin
        if (card_in_i == 4'd0 || card_in_i > 4'd10) begin
            card_val = 5'd10;
        end else begin
            card_val = {1'b0, card_in_i};
        end
    end

    assign card_is_ace = (card_val == 5'd1);

    // A single ace counts as 11 when that does not bust the hand; a second
    // soft ace could never fit, so one flag per hand is enough.
    function automatic logic [4:0] best_total(input logic [4:0] hard, input logic ace);
        if (ace && hard <= 5'd11) begin
            return hard + 5'd10;
        end
        return hard;
    endfunction

    state_t           state_q, state_d;
    logic [4:0]       p_hard_q, p_hard_d;
    logic [4:0]       d_hard_q, d_hard_d;
    logic             p_ace_q, p_ace_d;
    logic             d_ace_q, d_ace_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             win_q, win_d;
    logic             lose_q, lose_d;
    logic             push_q, push_d;
    logic             entry_q;
    logic             card_take;

    logic [4:0] player_total;
    logic [4:0] dealer_total;
    logic [4:0] p_hit_hard;
    logic       p_hit_ace;

    assign player_total = best_total(p_hard_q, p_ace_q);
    assign dealer_total = best_total(d_hard_q, d_ace_q);
    // Hard sums stay <= 21 whenever a card is added, so +10 fits in 5 bits.
    assign p_hit_hard   = p_hard_q + card_val;
    assign p_hit_ace    = p_ace_q | card_is_ace;

    // ---------------- FSM ----------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            p_hard_q <= '0;
            d_hard_q <= '0;
            p_ace_q  <= 1'b0;
            d_ace_q  <= 1'b0;
            gap_q    <= '0;
            win_q    <= 1'b0;
            lose_q   <= 1'b0;
            push_q   <= 1'b0;
            entry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            p_hard_q <= p_hard_d;
            d_hard_q <= d_hard_d;
            p_ace_q  <= p_ace_d;
            d_ace_q  <= d_ace_d;
            gap_q    <= gap_d;
            win_q    <= win_d;
            lose_q   <= lose_d;
            push_q   <= push_d;
            // Marks the first PLAYER cycle, where a natural 21 is detected.
            entry_q  <= (state_q == ST_DEAL_D2);
        end
    end

    always_comb begin
        state_d   = state_q;
        p_hard_d  = p_hard_q;
        d_hard_d  = d_hard_q;
        p_ace_d   = p_ace_q;
        d_ace_d   = d_ace_q;
        gap_d     = gap_q;
        win_d     = win_q;
        lose_d    = lose_q;
        push_d    = push_q;
        card_take = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hit_ev) begin
                    p_hard_d = '0;
                    d_hard_d = '0;
                    p_ace_d  = 1'b0;
                    d_ace_d  = 1'b0;
                    state_d  = ST_DEAL_P1;
                end
            end
            ST_DEAL_P1, ST_DEAL_P2: begin
                card_take = 1'b1;
                p_hard_d  = p_hit_hard;
                p_ace_d   = p_hit_ace;
                state_d   = (state_q == ST_DEAL_P1) ? ST_DEAL_D1 : ST_DEAL_D2;
            end
            ST_DEAL_D1, ST_DEAL_D2: begin
                card_take = 1'b1;
                d_hard_d  = d_hard_q + card_val;
                d_ace_d   = d_ace_q | card_is_ace;
                state_d   = (state_q == ST_DEAL_D1) ? ST_DEAL_P2 : ST_PLAYER;
            end
            ST_PLAYER: begin
                if ((entry_q && player_total == 5'd21) || stand_ev) begin
                    gap_d   = GAP_LOAD;
                    state_d = ST_DEALER;
                end else if (hit_ev) begin
                    card_take = 1'b1;
                    p_hard_d  = p_hit_hard;
                    p_ace_d   = p_hit_ace;
                    if (best_total(p_hit_hard, p_hit_ace) > 5'd21) begin
                        lose_d  = 1'b1;
                        state_d = ST_RESULT;
                    end
                end
            end
            ST_DEALER: begin
                if (dealer_total > 5'd21) begin
                    win_d   = 1'b1;
                    state_d = ST_RESULT;
                end else if (gap_q == '0) begin
                    if (dealer_total < STAND_TOTAL) begin
                        card_take = 1'b1;
                        d_hard_d  = d_hard_q + card_val;
                        d_ace_d   = d_ace_q | card_is_ace;
                        gap_d     = GAP_LOAD;
                    end else begin
                        win_d   = (player_total > dealer_total);
                        lose_d  = (player_total < dealer_total);
                        push_d  = (player_total == dealer_total);
                        state_d = ST_RESULT;
                    end
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            ST_RESULT: begin
                if (hit_ev || stand_ev) begin
                    win_d   = 1'b0;
                    lose_d  = 1'b0;
                    push_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- outputs ------------------------------------------------
    assign card_take_o    = card_take;
    assign player_total_o = player_total;
    assign dealer_total_o = dealer_total;
    assign state_o        = state_q;
    assign busy_o         = (state_q != ST_IDLE) && (state_q != ST_RESULT);
    assign win_o          = win_q;
    assign lose_o         = lose_q;
    assign push_o         = push_q;

endmodule

// File: tb/tb_blackjack_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_blackjack_round_ctrl
// Directed rounds with hand-computed totals and results. A background driver
// presents the next queued card whenever card_take is high and logs the cycle
// of every take so dealer draw spacing can be checked.
// -----------------------------------------------------------------------------
module tb_blackjack_round_ctrl;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       hit_n;
    logic       stand_n;
    logic [3:0] card_in;
    logic       card_take;
    logic [4:0] player_total;
    logic [4:0] dealer_total;
    logic [2:0] state;
    logic       busy;
    logic       win;
    logic       lose;
    logic       push;

    blackjack_round_ctrl #(
        .DEALER_STAND(17),
        .DRAW_GAP    (7)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .hit_n_i       (hit_n),
        .stand_n_i     (stand_n),
        .card_in_i     (card_in),
        .card_take_o   (card_take),
        .player_total_o(player_total),
        .dealer_total_o(dealer_total),
        .state_o       (state),
        .busy_o        (busy),
        .win_o         (win),
        .lose_o        (lose),
        .push_o        (push)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int take_count = 0;
    int seen_cyc = 0;
    int cards[$];
    int takes[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Card driver: card_take depends only on registered DUT state, so it is
    // stable at the falling edge and the value is ready for the next rise.
    initial begin
        int v;
        card_in = 4'd3;
        forever begin
            @(negedge clock);
            if (card_take === 1'b1) begin
                if (cards.size() > 0) v = cards.pop_front();
                else v = 10;
                card_in = 4'(v);
                take_count++;
                takes.push_back(cyc);
            end else begin
                card_in = 4'd3;
            end
        end
    end

    task automatic press(input logic h, input logic s, input int hold, input int settle);
        @(negedge clock);
        hit_n   = ~h;
        stand_n = ~s;
        repeat (hold) @(negedge clock);
        hit_n   = 1'b1;
        stand_n = 1'b1;
        repeat (settle) @(negedge clock);
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (state === target) break;
            @(negedge clock);
        end
        seen_cyc = cyc;
        check(tag, state, target);
    endtask

    task automatic start_round(input int c0, input int c1, input int c2, input int c3,
                               input string tag);
        cards.delete();
        takes.delete();
        take_count = 0;
        cards.push_back(c0);
        cards.push_back(c1);
        cards.push_back(c2);
        cards.push_back(c3);
        @(negedge clock);
        hit_n = 1'b0;
        repeat (2) @(negedge clock);
        hit_n = 1'b1;
        wait_state(3'd5, 20, {tag, "_player"});
    endtask

    task automatic stand_to_result(input string tag);
        press(1'b0, 1'b1, 2, 0);
        wait_state(3'd7, 100, {tag, "_result"});
        $display("round %s: player %0d dealer %0d win %0b lose %0b push %0b",
                 tag, player_total, dealer_total, win, lose, push);
    endtask

    task automatic ack(input string tag);
        press(1'b1, 1'b0, 2, 4);
        check({tag, "_ack_state"}, state, 3'd0);
        check({tag, "_ack_flags"}, {win, lose, push}, 3'b000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        hit_n   = 1'b1;
        stand_n = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_state", state, 3'd0);
        check("rst_totals", {player_total, dealer_total}, 10'd0);
        check("rst_outs", {card_take, busy, win, lose, push}, 5'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Stand in IDLE is ignored
        press(1'b0, 1'b1, 2, 5);
        check("idle_stand", state, 3'd0);

        // Deal 9,5,A,10: player soft 20, dealer 15; dealer draws 2 -> 17
        start_round(9, 5, 1, 10, "t2");
        check("t2_player", player_total, 5'd20);
        check("t2_dealer", dealer_total, 5'd15);
        check("t2_takes", take_count, 4);
        check("t2_busy", busy, 1'b1);
        cards.push_back(2);
        stand_to_result("t2");
        check("t2_dealer_end", dealer_total, 5'd17);
        check("t2_flags", {win, lose, push}, 3'b100);
        check("t2_takes_end", take_count, 5);
        check("t2_busy_end", busy, 1'b0);
        ack("t2");
        check("t2_held", player_total, 5'd20);

        // Soft 17 goes hard on a 10, then busts on a 9
        start_round(1, 10, 6, 7, "t3");
        check("t3_soft17", player_total, 5'd17);
        cards.push_back(10);
        press(1'b1, 1'b0, 2, 4);
        check("t3_hard17", player_total, 5'd17);
        check("t3_state", state, 3'd5);
        cards.push_back(9);
        press(1'b1, 1'b0, 2, 0);
        wait_state(3'd7, 10, "t3_result");
        check("t3_bust", player_total, 5'd26);
        check("t3_flags", {win, lose, push}, 3'b010);
        press(1'b0, 1'b1, 2, 4);
        check("t3_stand_ack", state, 3'd0);
        check("t3_ack_flags", {win, lose, push}, 3'b000);

        // Player 18; dealer 16 draws 5 -> 21 -> lose
        start_round(10, 10, 8, 6, "t4a");
        check("t4a_dealer", dealer_total, 5'd16);
        cards.push_back(5);
        stand_to_result("t4a");
        check("t4a_dealer_end", dealer_total, 5'd21);
        check("t4a_flags", {win, lose, push}, 3'b010);
        ack("t4a");

        // Same, dealer draws 8 -> 24: bust seen on the clock after the draw
        start_round(10, 10, 8, 6, "t4b");
        cards.push_back(8);
        stand_to_result("t4b");
        check("t4b_dealer_end", dealer_total, 5'd24);
        check("t4b_flags", {win, lose, push}, 3'b100);
        if (takes.size() == 5) check("t4b_bust_lat", seen_cyc - takes[4], 2);
        else check("t4b_draws", takes.size(), 5);
        ack("t4b");

        // Player 20 vs dealer 17: no dealer draw
        start_round(10, 10, 10, 7, "t4c");
        stand_to_result("t4c");
        check("t4c_flags", {win, lose, push}, 3'b100);
        check("t4c_takes", take_count, 4);
        ack("t4c");

        // Dealer 5 draws 4,4,5 -> 18 vs player 19; draws DRAW_GAP apart
        start_round(10, 2, 9, 3, "gap");
        cards.push_back(4);
        cards.push_back(4);
        cards.push_back(5);
        stand_to_result("gap");
        check("gap_dealer_end", dealer_total, 5'd18);
        check("gap_flags", {win, lose, push}, 3'b100);
        if (takes.size() == 7) begin
            check("gap_1", takes[5] - takes[4], 7);
            check("gap_2", takes[6] - takes[5], 7);
            check("gap_eval", seen_cyc - takes[6], 8);
        end else begin
            check("gap_draws", takes.size(), 7);
        end
        ack("gap");

        // Held button, bouncing button, simultaneous hit+stand
        start_round(2, 10, 2, 8, "t5");
        check("t5_player", player_total, 5'd4);
        cards.push_back(2);
        press(1'b1, 1'b0, 100, 5);
        check("t5_hold_player", player_total, 5'd6);
        check("t5_hold_takes", take_count, 5);
        cards.push_back(3);
        cards.push_back(4);
        @(negedge clock);
        hit_n = 1'b0;
        repeat (3) @(negedge clock);
        hit_n = 1'b1;
        repeat (3) @(negedge clock);
        hit_n = 1'b0;
        repeat (3) @(negedge clock);
        hit_n = 1'b1;
        repeat (6) @(negedge clock);
        check("t5_bounce_player", player_total, 5'd13);
        check("t5_bounce_takes", take_count, 7);
        press(1'b1, 1'b1, 2, 0);
        wait_state(3'd7, 30, "t5_result");
        check("t5_both_player", player_total, 5'd13);
        check("t5_both_takes", take_count, 7);
        check("t5_flags", {win, lose, push}, 3'b010);
        ack("t5");

        // Clamp 0 and 15 to 10; 19 vs 19 -> push; stand acknowledges
        start_round(0, 15, 9, 9, "t6");
        check("t6_player", player_total, 5'd19);
        check("t6_dealer", dealer_total, 5'd19);
        stand_to_result("t6");
        check("t6_flags", {win, lose, push}, 3'b001);
        check("t6_takes", take_count, 4);
        press(1'b0, 1'b1, 2, 4);
        check("t6_ack_state", state, 3'd0);
        check("t6_ack_flags", {win, lose, push}, 3'b000);
        check("t6_held", player_total, 5'd19);

        // Natural 21 moves to DEALER with no button
        start_round(1, 10, 10, 8, "nat");
        check("nat_player", player_total, 5'd21);
        wait_state(3'd6, 3, "nat_dealer");
        wait_state(3'd7, 30, "nat_result");
        check("nat_flags", {win, lose, push}, 3'b100);
        check("nat_takes", take_count, 4);
        ack("nat");

        // Asynchronous reset in the middle of the dealer phase
        start_round(10, 2, 9, 3, "t1");
        press(1'b0, 1'b1, 2, 0);
        wait_state(3'd6, 10, "t1_dealer");
        repeat (3) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("t1_state", state, 3'd0);
        check("t1_totals", {player_total, dealer_total}, 10'd0);
        check("t1_outs", {card_take, busy, win, lose, push}, 5'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        check("t1_after", state, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
